// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multicycle MIPS control FSM.
// Holds the state encoding, opcode/funct constants, ALU codes and the
// datapath mux select codes used by multicycle_ctrl and mc_alu_dec.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0]  WAIT_MAX_DEF = 4'd15;
    localparam logic [31:0] RESET_PC     = 32'h0000_3000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_ADDU = 4'd6;
    localparam logic [3:0] ALU_SUBU = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_NOR  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;

    localparam logic [1:0] B_RD2    = 2'd0;
    localparam logic [1:0] B_FOUR   = 2'd1;
    localparam logic [1:0] B_IMM    = 2'd2;
    localparam logic [1:0] B_IMM_SH = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RD1    = 2'd3;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // ALU code for an R-type funct; ALU_NOP marks an unsupported funct.
    function automatic logic [3:0] r_alu(input logic [5:0] f);
        case (f)
            F_ADD:   r_alu = ALU_ADD;
            F_ADDU:  r_alu = ALU_ADDU;
            F_SUB:   r_alu = ALU_SUB;
            F_SUBU:  r_alu = ALU_SUBU;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_XOR:   r_alu = ALU_XOR;
            F_NOR:   r_alu = ALU_NOR;
            F_SLT:   r_alu = ALU_SLT;
            F_SLTU:  r_alu = ALU_SLTU;
            default: r_alu = ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU/extension/legality decoder for the control FSM.
// Ports:
//   state_i    current FSM state
//   op_i       IR[31:26]
//   funct_i    IR[5:0]
//   alu_ctrl_o ALU operation code
//   ext_op_o   1 = sign-extend immediate, 0 = zero-extend
//   illegal_o  high in DECODE when op/funct is unsupported
module mc_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       ext_op_o,
    output logic       illegal_o
);

    logic [3:0] r_code;
    logic       is_r;
    logic       legal;

    always_comb begin
        r_code     = r_alu(funct_i);
        is_r       = op_i == OP_RTYPE;
        legal      = is_r ? (r_code != ALU_NOP || funct_i == F_JR)
                          : (op_i inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW});
        alu_ctrl_o = ALU_NOP;
        ext_op_o   = 1'b0;
        illegal_o  = 1'b0;
        case (state_i)
            S_FETCH: alu_ctrl_o = ALU_ADD;
            S_DECODE: begin
                alu_ctrl_o = ALU_ADD;
                ext_op_o   = 1'b1;
                illegal_o  = !legal;
            end
            S_EXEC: begin
                alu_ctrl_o = is_r ? r_code
                           : (op_i == OP_BEQ || op_i == OP_BNE) ? ALU_SUB
                           : (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
                ext_op_o   = op_i != OP_ORI;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath, stalls on the
// memory handshake and halts with a sticky fault on a memory timeout.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, funct, zero     IR fields and ALU zero flag
//   mem_ready           memory ack for mem_req
//   pc_wr, ir_wr        PC / IR load enables
//   mem_req, mem_we     memory request and write strobe
//   iord                memory address select (0 PC, 1 ALUOut)
//   alu_src_a/b         ALU operand selects
//   alu_ctrl, ext_op    ALU operation and immediate extension
//   reg_wr, reg_dst     register file write enable / destination select
//   wb_sel, pc_src      write-back data / next-PC selects
//   illegal, fault      unsupported-instruction pulse / sticky timeout flag
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [3:0] WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       ext_op,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       fault
);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] dec_alu;
    logic       dec_ext;
    logic       dec_ill;
    logic       is_r;

    mc_alu_dec u_dec (
        .state_i   (state_q),
        .op_i      (op),
        .funct_i   (funct),
        .alu_ctrl_o(dec_alu),
        .ext_op_o  (dec_ext),
        .illegal_o (dec_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = 4'd0;
        is_r      = op == OP_RTYPE;
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = B_RD2;
        alu_ctrl  = dec_alu;
        ext_op    = dec_ext;
        reg_wr    = 1'b0;
        reg_dst   = DST_RT;
        wb_sel    = WB_ALUOUT;
        pc_src    = PC_ALU;
        illegal   = dec_ill;
        fault     = state_q == S_HALT;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = B_FOUR;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed here so EXEC can load it from ALUOut.
                alu_src_b = B_IMM_SH;
                state_d   = S_EXEC;
                if (dec_ill) begin
                    state_d = S_FETCH;
                end else if (op == OP_J) begin
                    pc_wr   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = S_FETCH;
                end else if (op == OP_JAL) begin
                    reg_wr  = 1'b1;
                    reg_dst = DST_RA;
                    wb_sel  = WB_PC;
                    pc_wr   = 1'b1;
                    pc_src  = PC_JUMP;
                    state_d = S_FETCH;
                end else if (is_r && funct == F_JR) begin
                    pc_wr   = 1'b1;
                    pc_src  = PC_RD1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (is_r || op == OP_BEQ || op == OP_BNE) ? B_RD2 : B_IMM;
                if (op == OP_BEQ || op == OP_BNE) begin
                    pc_wr   = zero ^ (op == OP_BNE);
                    pc_src  = PC_ALUOUT;
                    state_d = S_FETCH;
                end else begin
                    state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = op == OP_SW;
                if (mem_ready) state_d = (op == OP_SW) ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = is_r ? DST_RD : DST_RT;
                wb_sel  = (op == OP_LW) ? WB_MDR : WB_ALUOUT;
                state_d = S_FETCH;
            end
            default: ;
        endcase
        // Count unacknowledged request cycles; an ack on the threshold cycle wins.
        if (mem_req && !mem_ready) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == WAIT_MAX - 4'd1) state_d = S_HALT;
        end
        // Reset forces every output low at once, dropping any in-flight request.
        if (rst) begin
            pc_wr     = 1'b0;
            ir_wr     = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            iord      = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'd0;
            alu_ctrl  = 4'd0;
            ext_op    = 1'b0;
            reg_wr    = 1'b0;
            reg_dst   = 2'd0;
            wb_sel    = 2'd0;
            pc_src    = 2'd0;
            illegal   = 1'b0;
            fault     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pc_wr, ir_wr, mem_req, mem_we, iord, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       ext_op, reg_wr;
    logic [1:0] reg_dst, wb_sel, pc_src;
    logic       illegal, fault;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_op(ext_op),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .wb_sel(wb_sel), .pc_src(pc_src),
        .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are settled 2 time units after the edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // FETCH cycle with an immediate memory ack; leaves the FSM in DECODE.
    task automatic do_fetch(input logic [5:0] o, input logic [5:0] f);
        op = o;
        funct = f;
        mem_ready = 1'b1;
        #1;
        check("fetch_mem_req", 32'(mem_req), 32'd1);
        check("fetch_ir_wr", 32'(ir_wr), 32'd1);
        check("fetch_pc_wr", 32'(pc_wr), 32'd1);
        tick;
    endtask

    initial begin
        rst = 1'b1;
        op = 6'h00;
        funct = 6'h00;
        zero = 1'b0;
        mem_ready = 1'b0;
        repeat (2) tick;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        #1;
        check("fetch_alu_src_b", 32'(alu_src_b), 32'd1);
        check("fetch_iord", 32'(iord), 32'd0);

        // add $3,$1,$2 : 4 cycles
        do_fetch(6'h00, 6'h20);
        check("add_dec_b", 32'(alu_src_b), 32'd3);
        check("add_dec_ext", 32'(ext_op), 32'd1);
        check("add_dec_reg_wr", 32'(reg_wr), 32'd0);
        tick;
        check("add_exec_a", 32'(alu_src_a), 32'd1);
        check("add_exec_b", 32'(alu_src_b), 32'd0);
        check("add_exec_alu", 32'(alu_ctrl), 32'd1);
        tick;
        check("add_wb_reg_wr", 32'(reg_wr), 32'd1);
        check("add_wb_reg_dst", 32'(reg_dst), 32'd1);
        check("add_wb_sel", 32'(wb_sel), 32'd0);
        tick;

        // lw with ack delayed 3 cycles in MEM : 8 cycles
        do_fetch(6'h23, 6'h00);
        tick;
        check("lw_exec_b", 32'(alu_src_b), 32'd2);
        check("lw_exec_alu", 32'(alu_ctrl), 32'd1);
        mem_ready = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check("lw_mem_req", 32'(mem_req), 32'd1);
            check("lw_mem_iord", 32'(iord), 32'd1);
            check("lw_mem_we", 32'(mem_we), 32'd0);
            tick;
        end
        check("lw_wb_reg_wr", 32'(reg_wr), 32'd1);
        check("lw_wb_sel", 32'(wb_sel), 32'd1);
        check("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
        tick;

        // beq taken : 3 cycles
        do_fetch(6'h04, 6'h00);
        tick;
        zero = 1'b1;
        #1;
        check("beq_pc_wr", 32'(pc_wr), 32'd1);
        check("beq_pc_src", 32'(pc_src), 32'd1);
        check("beq_alu", 32'(alu_ctrl), 32'd2);
        tick;
        check("beq_back_fetch", 32'(mem_req), 32'd1);

        // bne with zero=1 : not taken, 3 cycles
        do_fetch(6'h05, 6'h00);
        tick;
        check("bne_pc_wr", 32'(pc_wr), 32'd0);
        tick;
        check("bne_back_fetch", 32'(mem_req), 32'd1);
        zero = 1'b0;

        // jal : 2 cycles
        do_fetch(6'h03, 6'h00);
        check("jal_reg_wr", 32'(reg_wr), 32'd1);
        check("jal_reg_dst", 32'(reg_dst), 32'd2);
        check("jal_wb_sel", 32'(wb_sel), 32'd2);
        check("jal_pc_wr", 32'(pc_wr), 32'd1);
        check("jal_pc_src", 32'(pc_src), 32'd2);
        tick;
        check("jal_back_fetch", 32'(mem_req), 32'd1);

        // jr : 2 cycles
        do_fetch(6'h00, 6'h08);
        check("jr_pc_wr", 32'(pc_wr), 32'd1);
        check("jr_pc_src", 32'(pc_src), 32'd3);
        tick;
        check("jr_back_fetch", 32'(mem_req), 32'd1);

        // sw : 4 cycles
        do_fetch(6'h2B, 6'h00);
        tick;
        tick;
        check("sw_mem_req", 32'(mem_req), 32'd1);
        check("sw_mem_we", 32'(mem_we), 32'd1);
        check("sw_iord", 32'(iord), 32'd1);
        tick;
        check("sw_back_fetch", 32'(ir_wr), 32'd1);

        // ori : zero-extend, OR
        do_fetch(6'h0D, 6'h00);
        tick;
        check("ori_ext", 32'(ext_op), 32'd0);
        check("ori_alu", 32'(alu_ctrl), 32'd4);
        check("ori_b", 32'(alu_src_b), 32'd2);
        tick;
        check("ori_wb_reg_dst", 32'(reg_dst), 32'd0);
        tick;

        // illegal opcode
        do_fetch(6'h3F, 6'h00);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_reg_wr", 32'(reg_wr), 32'd0);
        check("ill_mem_req", 32'(mem_req), 32'd0);
        tick;
        check("ill_cleared", 32'(illegal), 32'd0);
        check("ill_back_fetch", 32'(mem_req), 32'd1);

        // ack on the threshold cycle wins
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("edge_wait_req", 32'(mem_req), 32'd1);
            tick;
        end
        mem_ready = 1'b1;
        #1;
        check("edge_ack_ir_wr", 32'(ir_wr), 32'd1);
        tick;
        check("edge_no_fault", 32'(fault), 32'd0);
        check("edge_in_decode", 32'(alu_src_b), 32'd3);
        tick;
        tick;
        tick;

        // timeout in FETCH -> HALT with sticky fault
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("to_wait_fault", 32'(fault), 32'd0);
            tick;
        end
        check("to_fault", 32'(fault), 32'd1);
        check("to_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        tick;
        check("halt_sticky", 32'(fault), 32'd1);
        check("halt_pc_wr", 32'(pc_wr), 32'd0);
        rst = 1'b1;
        tick;
        check("rst_clear_fault", 32'(fault), 32'd0);
        check("rst_mem_req_low", 32'(mem_req), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_fetch", 32'(mem_req), 32'd1);
        check("post_rst_fault", 32'(fault), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
